// File: rtl/mem_pkg.sv
// Shared types and constants for the two-requester DDR3 line arbiter.
package mem_pkg;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    CMD      = 2'd1,
    WAIT_RSP = 2'd2,
    RESP     = 2'd3
  } mem_arb_state_e;

  localparam int NREQ       = 2;
  localparam int REQ_ICACHE = 0;
  localparam int REQ_DCACHE = 1;

  function automatic logic [NREQ-1:0] idx_to_onehot(input logic idx);
    return idx ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/rr_arb.sv
// Two-way round-robin picker; the last-grant pointer is owned by the caller.
module rr_arb
  import mem_pkg::*;
(
  input  logic [NREQ-1:0] req,
  input  logic            last,
  output logic [NREQ-1:0] gnt,
  output logic            gnt_idx
);

  always_comb begin
    gnt_idx = 1'b0;
    gnt     = '0;
    case (req)
      2'b01:   gnt_idx = 1'b0;
      2'b10:   gnt_idx = 1'b1;
      2'b11:   gnt_idx = ~last;  // contention: favour whoever was not served last
      default: gnt_idx = 1'b0;
    endcase
    if (|req) gnt = idx_to_onehot(gnt_idx);
  end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory command/response port between icache and dcache line requests,
// one transaction at a time, with round-robin grants and a response watchdog.
module mem_arbiter
  import mem_pkg::*;
#(
  parameter int ADDR_W  = 28,
  parameter int LINE_W  = 128,
  parameter int TIMEOUT = 1023
) (
  input  logic                   clk_core,
  input  logic                   reset_n,
  input  logic [NREQ-1:0]        rq_valid,
  output logic [NREQ-1:0]        rq_ready,
  input  logic [NREQ-1:0]        rq_write,
  input  logic [NREQ*ADDR_W-1:0] rq_addr,
  input  logic [NREQ*LINE_W-1:0] rq_wdata,
  output logic [NREQ-1:0]        rs_valid,
  output logic                   rs_err,
  output logic [LINE_W-1:0]      rs_rdata,
  output logic                   mem_cmd_valid,
  input  logic                   mem_cmd_ready,
  output logic                   mem_cmd_write,
  output logic [ADDR_W-1:0]      mem_cmd_addr,
  output logic [LINE_W-1:0]      mem_cmd_wdata,
  input  logic                   mem_rsp_valid,
  input  logic [LINE_W-1:0]      mem_rsp_rdata,
  output logic                   err_spurious
);

  localparam int              CNT_W       = (TIMEOUT < 1) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TIMEOUT_CNT = CNT_W'(TIMEOUT);

  logic [ADDR_W-1:0] req_addr  [NREQ];
  logic [LINE_W-1:0] req_wdata [NREQ];

  for (genvar gi = 0; gi < NREQ; gi++) begin : g_unpack
    assign req_addr[gi]  = rq_addr[gi*ADDR_W +: ADDR_W];
    assign req_wdata[gi] = rq_wdata[gi*LINE_W +: LINE_W];
  end

  mem_arb_state_e    state_reg, state_next;
  logic              last_grant_reg;
  logic              owner_reg;
  logic              cmd_write_reg;
  logic [ADDR_W-1:0] cmd_addr_reg;
  logic [LINE_W-1:0] cmd_wdata_reg;
  logic [CNT_W-1:0]  cnt_reg;
  logic [LINE_W-1:0] rs_rdata_reg;
  logic              rs_err_reg;
  logic              err_spurious_reg;

  logic [NREQ-1:0]   gnt;
  logic              gnt_idx;
  logic              accept;
  logic              cmd_fire;
  logic              timed_out;

  rr_arb u_rr_arb (
    .req     (rq_valid),
    .last    (last_grant_reg),
    .gnt     (gnt),
    .gnt_idx (gnt_idx)
  );

  assign accept    = (state_reg == IDLE) && (|rq_valid);
  assign cmd_fire  = (state_reg == CMD) && mem_cmd_ready;
  assign timed_out = (cnt_reg == TIMEOUT_CNT);

  always_comb begin
    state_next    = state_reg;
    rq_ready      = '0;
    mem_cmd_valid = 1'b0;
    rs_valid      = '0;
    case (state_reg)
      IDLE: begin
        if (|rq_valid) begin
          // Keep the accept strobe quiet while reset is held, since nothing latches then.
          rq_ready   = reset_n ? gnt : '0;
          state_next = CMD;
        end
      end
      CMD: begin
        mem_cmd_valid = 1'b1;
        if (mem_cmd_ready) state_next = WAIT_RSP;
      end
      WAIT_RSP: begin
        if (mem_rsp_valid || timed_out) state_next = RESP;
      end
      RESP: begin
        rs_valid   = idx_to_onehot(owner_reg);
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_core or negedge reset_n) begin
    if (!reset_n) begin
      state_reg        <= IDLE;
      last_grant_reg   <= 1'b1;
      owner_reg        <= 1'b0;
      cmd_write_reg    <= 1'b0;
      cmd_addr_reg     <= '0;
      cmd_wdata_reg    <= '0;
      cnt_reg          <= '0;
      rs_rdata_reg     <= '0;
      rs_err_reg       <= 1'b0;
      err_spurious_reg <= 1'b0;
    end else begin
      state_reg <= state_next;

      if (accept) begin
        owner_reg      <= gnt_idx;
        last_grant_reg <= gnt_idx;
        cmd_write_reg  <= rq_write[gnt_idx];
        cmd_addr_reg   <= req_addr[gnt_idx];
        cmd_wdata_reg  <= req_wdata[gnt_idx];
      end

      if (cmd_fire) begin
        cnt_reg <= '0;
      end else if (state_reg == WAIT_RSP) begin
        cnt_reg <= cnt_reg + 1'b1;
      end

      // A response arriving on the expiry cycle still completes cleanly.
      if (state_reg == WAIT_RSP) begin
        if (mem_rsp_valid) begin
          rs_rdata_reg <= mem_rsp_rdata;
          rs_err_reg   <= 1'b0;
        end else if (timed_out) begin
          rs_rdata_reg <= '0;
          rs_err_reg   <= 1'b1;
        end
      end

      if (mem_rsp_valid && (state_reg != WAIT_RSP)) err_spurious_reg <= 1'b1;
    end
  end

  assign mem_cmd_write = cmd_write_reg;
  assign mem_cmd_addr  = cmd_addr_reg;
  assign mem_cmd_wdata = cmd_wdata_reg;
  assign rs_rdata      = rs_rdata_reg;
  assign rs_err        = rs_err_reg;
  assign err_spurious  = err_spurious_reg;

endmodule

// File: tb/tb_mem_arbiter.sv
// Randomized transaction-level bench for mem_arbiter: the bench plays both caches
// and the memory port, predicting grants, commands and responses from the rules.
module tb_mem_arbiter;

  localparam int ADDR_W  = 28;
  localparam int LINE_W  = 128;
  localparam int TIMEOUT = 40;

  logic                   clk_core = 1'b0;
  logic                   reset_n  = 1'b0;
  logic [1:0]             rq_valid;
  logic [1:0]             rq_ready;
  logic [1:0]             rq_write;
  logic [2*ADDR_W-1:0]    rq_addr;
  logic [2*LINE_W-1:0]    rq_wdata;
  logic [1:0]             rs_valid;
  logic                   rs_err;
  logic [LINE_W-1:0]      rs_rdata;
  logic                   mem_cmd_valid;
  logic                   mem_cmd_ready;
  logic                   mem_cmd_write;
  logic [ADDR_W-1:0]      mem_cmd_addr;
  logic [LINE_W-1:0]      mem_cmd_wdata;
  logic                   mem_rsp_valid;
  logic [LINE_W-1:0]      mem_rsp_rdata;
  logic                   err_spurious;

  mem_arbiter #(.ADDR_W(ADDR_W), .LINE_W(LINE_W), .TIMEOUT(TIMEOUT)) dut (
    .clk_core      (clk_core),
    .reset_n       (reset_n),
    .rq_valid      (rq_valid),
    .rq_ready      (rq_ready),
    .rq_write      (rq_write),
    .rq_addr       (rq_addr),
    .rq_wdata      (rq_wdata),
    .rs_valid      (rs_valid),
    .rs_err        (rs_err),
    .rs_rdata      (rs_rdata),
    .mem_cmd_valid (mem_cmd_valid),
    .mem_cmd_ready (mem_cmd_ready),
    .mem_cmd_write (mem_cmd_write),
    .mem_cmd_addr  (mem_cmd_addr),
    .mem_cmd_wdata (mem_cmd_wdata),
    .mem_rsp_valid (mem_rsp_valid),
    .mem_rsp_rdata (mem_rsp_rdata),
    .err_spurious  (err_spurious)
  );

  always #5 clk_core = ~clk_core;

  int vectors     = 0;
  int miscompares = 0;
  int txn_no      = 0;

  // Reference model: pending request per cache, round-robin memory, sticky spurious flag.
  bit                pend [2];
  bit                pw   [2];
  logic [ADDR_W-1:0] pa   [2];
  logic [LINE_W-1:0] pd   [2];
  int                last = 1;
  bit                spur = 1'b0;

  task automatic check_eq(input string tag, input logic [LINE_W-1:0] got,
                          input logic [LINE_W-1:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [LINE_W-1:0] rnd_line();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  task automatic set_req(input int r, input bit wr, input logic [ADDR_W-1:0] a,
                         input logic [LINE_W-1:0] d);
    pend[r] = 1'b1; pw[r] = wr; pa[r] = a; pd[r] = d;
  endtask

  task automatic new_req(input int r);
    set_req(r, 1'($urandom_range(0, 1)), ADDR_W'($urandom), rnd_line());
  endtask

  task automatic drive_reqs(input bit en);
    for (int r = 0; r < 2; r++) begin
      rq_valid[r]                    = en && pend[r];
      rq_write[r]                    = pw[r];
      rq_addr[r*ADDR_W +: ADDR_W]    = pa[r];
      rq_wdata[r*LINE_W +: LINE_W]   = pd[r];
    end
  endtask

  task automatic next_cycle();
    @(posedge clk_core);
    #1;
  endtask

  task automatic check_quiet(input string tag);
    check_eq({tag, "_rq_ready"}, rq_ready, 0);
    check_eq({tag, "_rs_valid"}, rs_valid, 0);
    check_eq({tag, "_cmd_valid"}, mem_cmd_valid, 0);
  endtask

  // One whole transaction: accept, command (with stall), wait, response.
  task automatic run_txn(input int stall, input int delay, input bit timeout,
                         input bit add_rnd, input bit abort, output int g);
    bit                cw;
    logic [ADDR_W-1:0] ca;
    logic [LINE_W-1:0] cd;
    logic [LINE_W-1:0] exp_d;
    bit                exp_err;
    int                silent;

    next_cycle();
    if (add_rnd)
      for (int r = 0; r < 2; r++)
        if (!pend[r] && $urandom_range(0, 2) != 0) new_req(r);
    if (!pend[0] && !pend[1]) new_req(int'($urandom_range(0, 1)));
    drive_reqs(1'b1);
    mem_cmd_ready = 1'b0;
    mem_rsp_valid = 1'b0;
    #1;
    g = (pend[0] && pend[1]) ? 1 - last : (pend[1] ? 1 : 0);
    check_eq("accept_rq_ready", rq_ready, 2'b01 << g);
    check_eq("accept_rs_valid", rs_valid, 0);
    last = g;
    cw = pw[g]; ca = pa[g]; cd = pd[g];
    pend[g] = 1'b0;

    for (int k = 0; k <= stall; k++) begin
      next_cycle();
      drive_reqs(1'($urandom_range(0, 1)));
      mem_cmd_ready = (k == stall);
      #1;
      check_eq("cmd_valid", mem_cmd_valid, 1);
      check_eq("cmd_write", mem_cmd_write, cw);
      check_eq("cmd_addr", mem_cmd_addr, ca);
      check_eq("cmd_wdata", mem_cmd_wdata, cd);
      check_eq("cmd_rq_ready", rq_ready, 0);
      check_eq("cmd_err_spurious", err_spurious, spur);
    end

    silent = timeout ? TIMEOUT + 1 : delay;
    for (int k = 0; k < silent; k++) begin
      next_cycle();
      mem_cmd_ready = 1'b0;
      drive_reqs(1'($urandom_range(0, 1)));
      if (abort && k == 2) begin
        drive_reqs(1'b1);
        reset_n = 1'b0;
        #1;
        check_quiet("rst");
        check_eq("rst_rs_err", rs_err, 0);
        check_eq("rst_err_spurious", err_spurious, 0);
        check_eq("rst_cmd_addr", mem_cmd_addr, 0);
        check_eq("rst_rs_rdata", rs_rdata, 0);
        next_cycle();
        check_quiet("rst_hold");
        reset_n = 1'b1;
        last = 1;
        spur = 1'b0;
        $display("txn %0d owner=%0d abandoned by reset", txn_no, g);
        txn_no++;
        return;
      end
      #1;
      check_quiet("wait");
    end

    if (!timeout) begin
      next_cycle();
      exp_d = rnd_line();
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = exp_d;
      #1;
      check_eq("rsp_rs_valid", rs_valid, 0);
      exp_err = 1'b0;
    end else begin
      exp_d = '0;
      exp_err = 1'b1;
    end

    next_cycle();
    mem_rsp_valid = 1'b0;
    drive_reqs(1'b1);
    #1;
    check_eq("resp_rs_valid", rs_valid, 2'b01 << g);
    check_eq("resp_rs_err", rs_err, exp_err);
    check_eq("resp_rs_rdata", rs_rdata, exp_d);
    check_eq("resp_rq_ready", rq_ready, 0);
    $display("txn %0d owner=%0d write=%0d addr=%h stall=%0d err=%0d",
             txn_no, g, cw, ca, stall, exp_err);
    txn_no++;
  endtask

  initial begin
    int g;
    rq_valid = '0; rq_write = '0; rq_addr = '0; rq_wdata = '0;
    mem_cmd_ready = 1'b0; mem_rsp_valid = 1'b0; mem_rsp_rdata = '0;
    pend[0] = 1'b0; pend[1] = 1'b0;
    drive_reqs(1'b0);

    repeat (3) next_cycle();
    check_quiet("reset");
    check_eq("reset_rs_err", rs_err, 0);
    check_eq("reset_err_spurious", err_spurious, 0);
    check_eq("reset_cmd_write", mem_cmd_write, 0);
    reset_n = 1'b1;

    // icache read, memory answers after 5 wait cycles
    set_req(0, 1'b0, 28'h0000100, '0);
    run_txn(0, 5, 1'b0, 1'b0, 1'b0, g);

    // both caches continuously requesting: alternate starting with icache after reset
    reset_n = 1'b0;
    next_cycle();
    reset_n = 1'b1;
    last = 1;
    for (int i = 0; i < 4; i++) begin
      for (int r = 0; r < 2; r++) if (!pend[r]) new_req(r);
      run_txn(0, 1, 1'b0, 1'b0, 1'b0, g);
      check_eq("grant_seq", g, i % 2);
    end
    pend[0] = 1'b0; pend[1] = 1'b0;

    // dcache write with command back-pressure
    set_req(1, 1'b1, 28'h0000200, rnd_line());
    run_txn(3, 2, 1'b0, 1'b0, 1'b0, g);

    // watchdog expiry, then a response exactly on the expiry cycle
    set_req(0, 1'b0, 28'h0000340, '0);
    run_txn(0, 0, 1'b1, 1'b0, 1'b0, g);
    set_req(1, 1'b0, 28'h0000380, '0);
    run_txn(1, TIMEOUT, 1'b0, 1'b0, 1'b0, g);

    // reset while waiting for memory; icache must win the first contended grant afterwards
    set_req(1, 1'b0, 28'h00003C0, '0);
    run_txn(0, 8, 1'b0, 1'b0, 1'b1, g);
    for (int r = 0; r < 2; r++) if (!pend[r]) new_req(r);
    run_txn(0, 3, 1'b0, 1'b0, 1'b0, g);
    check_eq("post_reset_grant", g, 0);

    // randomized traffic
    for (int i = 0; i < 120; i++) begin
      int gap;
      gap = int'($urandom_range(0, 2));
      for (int k = 0; k < gap; k++) begin
        next_cycle();
        drive_reqs(1'b0);
        #1;
        check_quiet("gap");
      end
      run_txn(int'($urandom_range(0, 3)),
              ($urandom_range(0, 9) == 0) ? TIMEOUT : int'($urandom_range(0, 10)),
              ($urandom_range(0, 9) == 0), 1'b1, 1'b0, g);
    end

    // stray memory response in IDLE: flag sets, stays set, nothing routed back
    next_cycle();
    drive_reqs(1'b0);
    mem_rsp_valid = 1'b1;
    #1;
    check_eq("spur_before", err_spurious, 0);
    spur = 1'b1;
    for (int k = 0; k < 3; k++) begin
      next_cycle();
      mem_rsp_valid = 1'b0;
      #1;
      check_eq("spur_flag", err_spurious, 1);
      check_quiet("spur");
    end
    run_txn(1, 2, 1'b0, 1'b1, 1'b0, g);
    next_cycle();
    #1;
    check_eq("spur_sticky", err_spurious, 1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
